v8_peak_detector: RTL and testbench

- Consumes the trapezoidal-shaper output stream (one signed sample per clk) and detects pulses crossing a programmable threshold.
- For each qualified pulse, captures peak amplitude, peak timestamp and time-over-threshold width.
- Queues events in a small FIFO drained through a valid/ready handshake toward the readout/histogram stage.
- Sits directly downstream of the v8 shaping filter.

---
 rtl/v8_peak_detector.sv | 146 ++++++++++++++
 tb/tb_v8_peak_detector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/v8_peak_detector.sv
// Peak detector for the v8 shaper stream: qualifies pulses above a threshold and
// queues {peak amplitude, peak timestamp, time-over-threshold} events in a FWFT FIFO.
module v8_peak_detector #(
    parameter int DATA_W     = 16,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 16,
    parameter int MIN_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filter_data,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     enable,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic signed [DATA_W-1:0] event_amp,
    output logic [TS_W-1:0]          event_ts,
    output logic [7:0]               event_width,
    output logic [15:0]              overflow_cnt,
    output logic                     busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HC_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [7:0]       MIN_W8    = 8'(MIN_WIDTH);
    localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLDOFF - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ABOVE, HOLD} state_t;

    state_t                     state_q;
    logic [TS_W-1:0]            ts_q;
    logic signed [DATA_W-1:0]   peak_q;
    logic [TS_W-1:0]            peakTs_q;
    logic [7:0]                 width_q;
    logic [HC_W-1:0]            hcnt_q;
    logic signed [DATA_W-1:0]   memAmp_q   [FIFO_DEPTH];
    logic [TS_W-1:0]            memTs_q    [FIFO_DEPTH];
    logic [7:0]                 memWidth_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wrPtr_q;
    logic [PTR_W-1:0]           rdPtr_q;
    logic [PTR_W:0]             count_q;
    logic [15:0]                ovf_q;

    logic       above;
    logic       full;
    logic       pushReq;
    logic       popReq;
    logic       pushOk;
    logic [7:0] widthInc_d;

    always_comb begin
        above      = filter_data > threshold;
        full       = (count_q == DEPTH_C);
        popReq     = event_valid && event_ready;
        pushReq    = (state_q == ABOVE) && enable && !above && (width_q >= MIN_W8);
        // A full FIFO still accepts the push if the head leaves on the same edge.
        pushOk     = pushReq && (!full || popReq);
        widthInc_d = (width_q == 8'hFF) ? 8'hFF : width_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            peak_q   <= '0;
            peakTs_q <= '0;
            width_q  <= '0;
            hcnt_q   <= '0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                memAmp_q[i]   <= '0;
                memTs_q[i]    <= '0;
                memWidth_q[i] <= '0;
            end
        end else begin
            ts_q <= ts_q + TS_W'(1);

            case (state_q)
                IDLE: begin
                    if (enable && above) begin
                        state_q  <= ABOVE;
                        peak_q   <= filter_data;
                        peakTs_q <= ts_q;
                        width_q  <= 8'd1;
                    end
                end
                ABOVE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (above) begin
                        width_q <= widthInc_d;
                        // Strict compare keeps the first sample of a flat top.
                        if (filter_data > peak_q) begin
                            peak_q   <= filter_data;
                            peakTs_q <= ts_q;
                        end
                    end else if (width_q >= MIN_W8) begin
                        state_q <= (HOLDOFF == 0) ? IDLE : HOLD;
                        hcnt_q  <= HOLD_INIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (hcnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        hcnt_q <= hcnt_q - HC_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (pushOk) begin
                memAmp_q[wrPtr_q]   <= peak_q;
                memTs_q[wrPtr_q]    <= peakTs_q;
                memWidth_q[wrPtr_q] <= width_q;
                wrPtr_q             <= wrPtr_q + PTR_W'(1);
            end
            if (pushReq && !pushOk && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
            if (popReq) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (pushOk && !popReq) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!pushOk && popReq) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    assign event_valid  = (count_q != '0);
    assign event_amp    = memAmp_q[rdPtr_q];
    assign event_ts     = memTs_q[rdPtr_q];
    assign event_width  = memWidth_q[rdPtr_q];
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_v8_peak_detector.sv
// Directed bench for v8_peak_detector: table-driven pulse shapes plus hand-written
// holdoff, FIFO overflow, full push/pop and abort/negative-threshold sequences.
module tb_v8_peak_detector;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] filterData;
    logic signed [15:0] threshold;
    logic               enable;
    logic               eventValid;
    logic               eventReady;
    logic signed [15:0] eventAmp;
    logic [31:0]        eventTs;
    logic [7:0]         eventWidth;
    logic [15:0]        overflowCnt;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int expTs [6];

    typedef struct {
        logic signed [15:0] data;
        logic               expValid;
        logic               expBusy;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    v8_peak_detector #(
        .DATA_W(16), .TS_W(32), .FIFO_DEPTH(4), .HOLDOFF(16), .MIN_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .filter_data(filterData), .threshold(threshold),
        .enable(enable), .event_valid(eventValid), .event_ready(eventReady),
        .event_amp(eventAmp), .event_ts(eventTs), .event_width(eventWidth),
        .overflow_cnt(overflowCnt), .busy(busy)
    );

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sample per call; cyc tracks the timestamp the DUT attaches to that sample.
    task automatic applyStimulus(input logic signed [15:0] d);
        filterData = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        reset      = 1'b0;
        filterData = '0;
        eventReady = 1'b0;
        enable     = 1'b1;
        threshold  = 16'sd100;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic checkHead(input string tag, input int amp, input int ts, input int width);
        checkOutput({tag, " amp"}, eventAmp, amp);
        checkOutput({tag, " ts"}, eventTs, ts);
        checkOutput({tag, " width"}, eventWidth, width);
    endtask

    task automatic sendPulse(input int amp, input int k);
        applyStimulus(16'(amp - 50));
        expTs[k] = cyc;
        applyStimulus(16'(amp));
        repeat (17) applyStimulus(16'sd0);
    endtask

    initial begin
        vecs[0]  = '{16'sd0,   1'b0, 1'b0};
        vecs[1]  = '{16'sd150, 1'b0, 1'b1};
        vecs[2]  = '{16'sd300, 1'b0, 1'b1};
        vecs[3]  = '{16'sd500, 1'b0, 1'b1};
        vecs[4]  = '{16'sd500, 1'b0, 1'b1};
        vecs[5]  = '{16'sd200, 1'b0, 1'b1};
        vecs[6]  = '{16'sd50,  1'b1, 1'b1};
        vecs[7]  = '{16'sd0,   1'b1, 1'b1};
        vecs[8]  = '{16'sd0,   1'b0, 1'b0};
        vecs[9]  = '{16'sd150, 1'b0, 1'b1};
        vecs[10] = '{16'sd0,   1'b0, 1'b0};
        vecs[11] = '{16'sd150, 1'b0, 1'b1};
        vecs[12] = '{16'sd160, 1'b0, 1'b1};
        vecs[13] = '{16'sd0,   1'b1, 1'b1};

        // Reset state
        doReset();
        checkOutput("rst valid", eventValid, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst ovf", overflowCnt, 0);
        checkHead("rst", 0, 0, 0);

        // Basic pulse, then single-sample reject followed by immediate re-arm
        for (int i = 0; i < 14; i++) begin
            if (i == 8) doReset();
            applyStimulus(vecs[i].data);
            checkOutput($sformatf("vec%0d valid", i), eventValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
            if (i == 7) checkHead("basic", 500, 3, 5);
        end
        checkHead("rearm", 160, 4, 2);

        // Holdoff: re-trigger at 10 cycles ignored, at 17 cycles accepted
        doReset();
        applyStimulus(16'sd0);
        applyStimulus(16'sd200);
        applyStimulus(16'sd200);
        applyStimulus(16'sd0);
        checkOutput("hold ev1 valid", eventValid, 1);
        checkHead("hold ev1", 200, 1, 2);
        eventReady = 1'b1;
        applyStimulus(16'sd0);
        eventReady = 1'b0;
        checkOutput("hold pop valid", eventValid, 0);
        while (cyc < 13) applyStimulus(16'sd0);
        repeat (3) applyStimulus(16'sd300);
        while (cyc < 19) applyStimulus(16'sd0);
        checkOutput("hold busy late", busy, 1);
        applyStimulus(16'sd0);
        checkOutput("hold busy end", busy, 0);
        checkOutput("hold ignored", eventValid, 0);
        applyStimulus(16'sd180);
        checkOutput("hold retrig busy", busy, 1);
        applyStimulus(16'sd250);
        applyStimulus(16'sd250);
        applyStimulus(16'sd0);
        checkOutput("hold ev2 valid", eventValid, 1);
        checkHead("hold ev2", 250, 21, 3);

        // Six pulses into a depth-4 FIFO with no consumer
        doReset();
        applyStimulus(16'sd0);
        for (int k = 0; k < 6; k++) sendPulse(200 + 10 * k, k);
        checkOutput("ovf valid", eventValid, 1);
        checkOutput("ovf count", overflowCnt, 2);
        eventReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkHead($sformatf("ovf pop%0d", k), 200 + 10 * k, expTs[k], 2);
            applyStimulus(16'sd0);
            checkOutput($sformatf("ovf valid%0d", k), eventValid, (k < 3) ? 1 : 0);
        end
        eventReady = 1'b0;

        // Full FIFO: push and pop on the same edge
        doReset();
        applyStimulus(16'sd0);
        for (int k = 0; k < 4; k++) sendPulse(200 + 10 * k, k);
        applyStimulus(16'sd190);
        expTs[4] = cyc;
        applyStimulus(16'sd240);
        eventReady = 1'b1;
        applyStimulus(16'sd0);
        eventReady = 1'b0;
        checkOutput("full ovf", overflowCnt, 0);
        checkOutput("full valid", eventValid, 1);
        eventReady = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checkHead($sformatf("full pop%0d", k), 200 + 10 * k, expTs[k], 2);
            applyStimulus(16'sd0);
            checkOutput($sformatf("full valid%0d", k), eventValid, (k < 4) ? 1 : 0);
        end
        eventReady = 1'b0;

        // Reset mid-pulse, enable drop mid-pulse, negative threshold
        doReset();
        applyStimulus(16'sd0);
        applyStimulus(16'sd200);
        applyStimulus(16'sd300);
        checkOutput("abort busy", busy, 1);
        reset = 1'b0;
        applyStimulus(16'sd300);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst valid", eventValid, 0);
        filterData = 16'sd0;
        reset = 1'b1;
        cyc   = 0;
        repeat (3) applyStimulus(16'sd0);
        checkOutput("midrst noev", eventValid, 0);
        applyStimulus(16'sd200);
        applyStimulus(16'sd300);
        enable = 1'b0;
        applyStimulus(16'sd400);
        checkOutput("disable busy", busy, 0);
        enable = 1'b1;
        applyStimulus(16'sd0);
        applyStimulus(16'sd0);
        checkOutput("disable noev", eventValid, 0);
        threshold = -16'sd50;
        applyStimulus(-16'sd100);
        checkOutput("neg idle busy", busy, 0);
        applyStimulus(-16'sd20);
        expTs[0] = cyc;
        applyStimulus(-16'sd10);
        applyStimulus(-16'sd60);
        checkOutput("neg valid", eventValid, 1);
        checkHead("neg", -10, expTs[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
